add_sub_unit: RTL and testbench

Parameterised two's-complement adder/subtractor with a registered result. It is the shared arithmetic primitive behind the ALU's ADD/SUB/ADDI paths and the branch-compare logic. A single control bit selects the operation: a+b or a-b. Result and carry-out are captured one clock after the operands are presented.

---
 rtl/add_sub_pkg.sv | 17 +
 rtl/add_sub_unit_ripple_adder.sv | 29 ++
 rtl/add_sub_unit.sv | 107 ++++++++++
 tb/tb_add_sub_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/add_sub_pkg.sv
// Shared definitions for the registered two's-complement adder/subtractor.
// The op encoding matches the sub1_add0 control bit; result_t is wide enough for any legal width.
package add_sub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int MAX_WIDTH = 64;

  typedef struct packed {
    logic [MAX_WIDTH-1:0] y;
    logic                 cout;
    logic                 overflow;
    logic                 zero;
  } result_t;

endpackage

// File: rtl/add_sub_unit_ripple_adder.sv
// Combinational ripple-carry adder: {cout_o, sum_o} = a_i + b_i + cin_i.
// Each stage owns its carry-in so the chain is a set of distinct nets rather than one self-referencing vector.
module ripple_adder #(
  parameter int BitWidth = 8
) (
  input  logic [BitWidth-1:0] a_i,
  input  logic [BitWidth-1:0] b_i,
  input  logic                cin_i,
  output logic [BitWidth-1:0] sum_o,
  output logic                cout_o
);

  for (genvar i = 0; i < BitWidth; i++) begin : g_fa
    logic c_in;
    logic c_out;

    if (i == 0) begin : g_first
      assign c_in = cin_i;
    end else begin : g_chain
      assign c_in = g_fa[i-1].c_out;
    end

    assign sum_o[i] = a_i[i] ^ b_i[i] ^ c_in;
    assign c_out    = (a_i[i] & b_i[i]) | (c_in & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = g_fa[BitWidth-1].c_out;

endmodule

// File: rtl/add_sub_unit.sv
// Registered adder/subtractor: y/cout = a +/- b one clock after in_valid.
// Define ADD_SUB_FLAGS_EN to add the registered signed-overflow and zero flag ports.
module add_sub_unit
  import add_sub_pkg::*;
#(
  parameter int BitWidth = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [BitWidth-1:0] a,
  input  logic [BitWidth-1:0] b,
  input  logic                sub1_add0,
  output logic                out_valid,
  output logic [BitWidth-1:0] y,
`ifdef ADD_SUB_FLAGS_EN
  output logic                overflow,
  output logic                zero,
`endif
  output logic                cout
);

  localparam int MSB = BitWidth - 1;

  logic                is_sub;
  logic [BitWidth-1:0] b_eff;
  logic [BitWidth-1:0] sum;
  logic                sum_cout;

  // Subtraction is a + ~b + 1, so the op bit doubles as the carry-in.
  assign is_sub = (sub1_add0 == OP_SUB);
  assign b_eff  = is_sub ? ~b : b;

  ripple_adder #(
    .BitWidth(BitWidth)
  ) u_adder (
    .a_i   (a),
    .b_i   (b_eff),
    .cin_i (is_sub),
    .sum_o (sum),
    .cout_o(sum_cout)
  );

  logic                valid_q, valid_d;
  logic [BitWidth-1:0] y_q,     y_d;
  logic                cout_q,  cout_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    valid_d = in_valid;
    y_d     = y_q;
    cout_d  = cout_q;
    if (in_valid) begin
      y_d    = sum;
      cout_d = sum_cout;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      y_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      y_q     <= y_d;
      cout_q  <= cout_d;
    end
  end

  assign out_valid = valid_q;
  assign y         = y_q;
  assign cout      = cout_q;

`ifdef ADD_SUB_FLAGS_EN
  logic ovf_q,  ovf_d;
  logic zero_q, zero_d;

  // Overflow: operands agree in sign but the result does not.
  always_comb begin
    ovf_d  = ovf_q;
    zero_d = zero_q;
    if (in_valid) begin
      ovf_d  = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]);
      zero_d = (sum == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign overflow = ovf_q;
  assign zero     = zero_q;
`else
  // MSB is only needed by the flag logic.
  localparam int UnusedMsb = MSB;
`endif

endmodule

// File: tb/tb_add_sub_unit.sv
// Self-checking bench for add_sub_unit (BitWidth=8) with a scoreboard queue of expected results.
// Flag checks are compiled in when ADD_SUB_FLAGS_EN is defined.
module tb_add_sub_unit;
  import add_sub_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a, b;
  logic         sub1_add0;
  logic         out_valid;
  logic [W-1:0] y;
  logic         cout;
`ifdef ADD_SUB_FLAGS_EN
  logic         overflow, zero;
`endif

  int checks = 0;
  int errors = 0;

  result_t sb_q[$];
  result_t held;

  always #5 clk = ~clk;

  add_sub_unit #(.BitWidth(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .sub1_add0(sub1_add0),
    .out_valid(out_valid),
    .y        (y),
`ifdef ADD_SUB_FLAGS_EN
    .overflow (overflow),
    .zero     (zero),
`endif
    .cout     (cout)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model from integer arithmetic, independent of the adder structure.
  function automatic result_t model(input int unsigned av, input int unsigned bv, input logic op);
    result_t r;
    int sa, sb, sr;
    int unsigned full;
    r = '0;
    sa = (av >= 128) ? int'(av) - 256 : int'(av);
    sb = (bv >= 128) ? int'(bv) - 256 : int'(bv);
    if (op == OP_ADD) begin
      full   = av + bv;
      r.cout = (full >= 256);
      sr     = sa + sb;
    end else begin
      full   = av - bv;
      r.cout = (av >= bv);
      sr     = sa - sb;
    end
    r.y        = 64'(full & 32'hFF);
    r.overflow = (sr > 127) || (sr < -128);
    r.zero     = (r.y == 0);
    return r;
  endfunction

  // Drive one cycle of stimulus, cross the edge, then compare #1 later.
  task automatic step(input logic v, input int unsigned av, input int unsigned bv, input logic op);
    result_t e;
    in_valid  = v;
    a         = W'(av);
    b         = W'(bv);
    sub1_add0 = op;
    if (v) sb_q.push_back(model(av, bv, op));
    @(posedge clk);
    #1;
    check("out_valid", 64'(out_valid), 64'(v));
    if (v) begin
      if (sb_q.size() == 0) begin
        check("sb_empty", 64'(sb_q.size()), 64'd1);
      end else begin
        e = sb_q.pop_front();
        held = e;
      end
    end else begin
      e = held;
    end
    check($sformatf("y a=%0d b=%0d op=%0d v=%0d", av, bv, op, v), 64'(y), e.y);
    check($sformatf("cout a=%0d b=%0d op=%0d v=%0d", av, bv, op, v), 64'(cout), 64'(e.cout));
`ifdef ADD_SUB_FLAGS_EN
    check($sformatf("ovf a=%0d b=%0d op=%0d", av, bv, op), 64'(overflow), 64'(e.overflow));
    check($sformatf("zero a=%0d b=%0d op=%0d", av, bv, op), 64'(zero), 64'(e.zero));
`endif
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_y"}, 64'(y), 64'd0);
    check({tag, "_cout"}, 64'(cout), 64'd0);
`ifdef ADD_SUB_FLAGS_EN
    check({tag, "_ovf"}, 64'(overflow), 64'd0);
    check({tag, "_zero"}, 64'(zero), 64'd0);
`endif
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    sub1_add0 = OP_ADD;
    held      = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Add sweeps
    for (int i = 0; i < 16; i++) step(1'b1, i, 0, OP_ADD);
    for (int i = 0; i < 16; i++) step(1'b1, 15, i, OP_ADD);

    // Sub sweep, ending in zero result
    for (int i = 0; i < 16; i++) step(1'b1, 15, i, OP_SUB);

    // Wrap and borrow
    step(1'b1, 255, 1, OP_ADD);
    step(1'b1, 0, 1, OP_SUB);
    step(1'b1, 255, 255, OP_ADD);

    // Signed overflow cases
    step(1'b1, 127, 1, OP_ADD);
    step(1'b1, 128, 1, OP_SUB);
    step(1'b1, 5, 3, OP_SUB);
    step(1'b1, 128, 128, OP_ADD);

    // Valid gating: result held while idle, inputs ignored
    step(1'b1, 200, 17, OP_SUB);
    step(1'b0, 1, 1, OP_ADD);
    step(1'b0, 99, 42, OP_SUB);
    step(1'b0, 255, 255, OP_ADD);

    // Back-to-back random operations
    for (int i = 0; i < 24; i++)
      step(1'b1, $urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom_range(0, 1)));

    // Mid-stream asynchronous reset discards the pending result
    step(1'b1, 85, 34, OP_ADD);
    in_valid  = 1'b1;
    a         = 8'd200;
    b         = 8'd100;
    sub1_add0 = OP_ADD;
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_state("async_reset");
    sb_q.delete();
    held = '0;
    #2;
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state("post_reset");

    // Operation resumes after reset
    step(1'b1, 10, 20, OP_SUB);
    step(1'b1, 10, 20, OP_ADD);

    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
